bus_datapath: RTL and testbench

- Single-bus 32-bit CPU datapath slice.
- Contains 16 general-purpose registers, PC, IR, Y, HI, LO, Z_HI/Z_LO, an MDR with a memory/bus input mux, a 32-to-5 out-strobe encoder, a 24-source bus multiplexer, and a logic/negate ALU.
- Sits between the control unit (drives all strobes) and the memory interface (supplies Mdatain).

---
 rtl/bus_datapath.sv | 160 ++++++++++++++++
 tb/tb_bus_datapath.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_datapath.sv
// Single-bus 32-bit datapath slice: GPRs, PC/IR/Y/HI/LO/Z/MDR/MAR, strobe encoder, bus mux, logic/negate ALU.
// Latency: bus mux and ALU are combinational; every register loads on the rising edge after its enable.
// Backpressure: none; the control unit owns every strobe and the datapath always accepts it.
// Optional feature: define BUS_CONFLICT_CHECK_EN to add the bus_conflict output (two or more drive strobes).
module bus_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [15:0]      Rin,
    input  logic [15:0]      Rout,
    input  logic             PCin,
    input  logic             IncPC,
    input  logic             IRin,
    input  logic             Yin,
    input  logic             Zin,
    input  logic             MARin,
    input  logic             MDRin,
    input  logic             HIin,
    input  logic             LOin,
    input  logic             PCout,
    input  logic             MDRout,
    input  logic             HIout,
    input  logic             LOout,
    input  logic             Zhighout,
    input  logic             Zlowout,
    input  logic             InPortout,
    input  logic             Cout,
    input  logic             Read,
    input  logic             AND,
    input  logic             OR,
    input  logic             NOT,
    input  logic             NEG,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic [WIDTH-1:0] InPort,
`ifdef BUS_CONFLICT_CHECK_EN
    output logic             bus_conflict,
`endif
    output logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] MAR,
    output logic [WIDTH-1:0] IR_q
);

    logic [WIDTH-1:0] gpr [16];
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] zhi_q;
    logic [WIDTH-1:0] zlo_q;
    logic [WIDTH-1:0] mdr_q;
    logic [WIDTH-1:0] mar_q;
    logic [WIDTH-1:0] ir_q;

    logic [31:0]      enc_in;
    logic [4:0]       enc_idx;
    logic             enc_vld;
    logic [WIDTH-1:0] alu_res;

    // Drive strobes packed into encoder order; upper byte is unused and tied low
    assign enc_in = {8'h00, Cout, InPortout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout, Rout};

    // Priority encoder: scan high to low so the lowest set strobe is the last one written
    always_comb begin
        enc_idx = 5'd0;
        enc_vld = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (enc_in[i]) begin
                enc_idx = 5'(i);
                enc_vld = 1'b1;
            end
        end
    end

`ifdef BUS_CONFLICT_CHECK_EN
    // More than one bit set means clearing the lowest set bit still leaves something
    assign bus_conflict = ((enc_in & (enc_in - 32'd1)) != 32'd0);
`endif

    // Bus multiplexer; an idle bus reads as zero
    always_comb begin
        BusMuxOut = '0;
        if (enc_vld) begin
            case (enc_idx)
                5'd16:   BusMuxOut = hi_q;
                5'd17:   BusMuxOut = lo_q;
                5'd18:   BusMuxOut = zhi_q;
                5'd19:   BusMuxOut = zlo_q;
                5'd20:   BusMuxOut = pc_q;
                5'd21:   BusMuxOut = mdr_q;
                5'd22:   BusMuxOut = InPort;
                5'd23:   BusMuxOut = {{(WIDTH-19){ir_q[18]}}, ir_q[18:0]};
                default: BusMuxOut = (enc_idx < 5'd16) ? gpr[enc_idx[3:0]] : '0;
            endcase
        end
    end

    // ALU with fixed op priority AND > OR > NOT > NEG, pass-through of B otherwise
    always_comb begin
        alu_res = BusMuxOut;
        if (AND)
            alu_res = y_q & BusMuxOut;
        else if (OR)
            alu_res = y_q | BusMuxOut;
        else if (NOT)
            alu_res = ~BusMuxOut;
        else if (NEG)
            alu_res = '0 - BusMuxOut;
    end

    // General-purpose register file; each register loads the bus on its own enable
    always_ff @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (clr)
                gpr[i] <= '0;
            else if (Rin[i])
                gpr[i] <= BusMuxOut;
        end
    end

    // Special registers; IncPC wins over PCin, MDR picks memory or bus by Read
    always_ff @(posedge clk) begin
        if (clr) begin
            pc_q  <= '0;
            ir_q  <= '0;
            y_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            zhi_q <= '0;
            zlo_q <= '0;
            mdr_q <= '0;
            mar_q <= '0;
        end else begin
            if (IncPC)
                pc_q <= pc_q + WIDTH'(1);
            else if (PCin)
                pc_q <= BusMuxOut;
            if (IRin)
                ir_q <= BusMuxOut;
            if (Yin)
                y_q <= BusMuxOut;
            if (HIin)
                hi_q <= BusMuxOut;
            if (LOin)
                lo_q <= BusMuxOut;
            if (MARin)
                mar_q <= BusMuxOut;
            if (MDRin)
                mdr_q <= Read ? Mdatain : BusMuxOut;
            if (Zin) begin
                zlo_q <= alu_res;
                zhi_q <= {WIDTH{alu_res[WIDTH-1]}};
            end
        end
    end

    assign MAR  = mar_q;
    assign IR_q = ir_q;

endmodule

// File: tb/tb_bus_datapath.sv
// Directed bench for bus_datapath: loads registers through InPort/Mdatain and reads them back over the bus.
// Latency: one clock per register transfer; bus reads are sampled mid-cycle.
// Backpressure: not applicable; the bench drives every strobe directly.
module tb_bus_datapath;

    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] Rin, Rout;
    logic        PCin, IncPC, IRin, Yin, Zin, MARin, MDRin, HIin, LOin;
    logic        PCout, MDRout, HIout, LOout, Zhighout, Zlowout, InPortout, Cout;
    logic        Read, AND, OR, NOT, NEG;
    logic [31:0] Mdatain, InPort;
    logic [31:0] BusMuxOut, MAR, IR_q;
`ifdef BUS_CONFLICT_CHECK_EN
    logic        bus_conflict;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bus_datapath #(.WIDTH(32)) dut (
        .clk(clk), .clr(clr), .Rin(Rin), .Rout(Rout),
        .PCin(PCin), .IncPC(IncPC), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .MARin(MARin), .MDRin(MDRin), .HIin(HIin), .LOin(LOin),
        .PCout(PCout), .MDRout(MDRout), .HIout(HIout), .LOout(LOout),
        .Zhighout(Zhighout), .Zlowout(Zlowout), .InPortout(InPortout), .Cout(Cout),
        .Read(Read), .AND(AND), .OR(OR), .NOT(NOT), .NEG(NEG),
        .Mdatain(Mdatain), .InPort(InPort),
`ifdef BUS_CONFLICT_CHECK_EN
        .bus_conflict(bus_conflict),
`endif
        .BusMuxOut(BusMuxOut), .MAR(MAR), .IR_q(IR_q)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        clr = 0; Rin = '0; Rout = '0;
        PCin = 0; IncPC = 0; IRin = 0; Yin = 0; Zin = 0; MARin = 0; MDRin = 0; HIin = 0; LOin = 0;
        PCout = 0; MDRout = 0; HIout = 0; LOout = 0; Zhighout = 0; Zlowout = 0; InPortout = 0; Cout = 0;
        Read = 0; AND = 0; OR = 0; NOT = 0; NEG = 0;
    endtask

    // Apply the current strobes across one rising edge, then drop them
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Raise one drive strobe by encoder index
    task automatic drive(input int src);
        case (src)
            16: HIout = 1;
            17: LOout = 1;
            18: Zhighout = 1;
            19: Zlowout = 1;
            20: PCout = 1;
            21: MDRout = 1;
            22: InPortout = 1;
            23: Cout = 1;
            default: Rout[src] = 1;
        endcase
    endtask

    // Put one source on the bus mid-cycle and compare
    task automatic rd(input string tag, input int src, input logic [31:0] exp);
        drive(src);
        #1;
        chk(tag, BusMuxOut, exp);
        idle();
        #1;
    endtask

    // Load GPR dst from InPort with value v
    task automatic ld_r(input int dst, input logic [31:0] v);
        InPort = v; InPortout = 1; Rin[dst] = 1;
        tick();
    endtask

    initial begin
        idle();
        Mdatain = '0;
        InPort  = '0;
        clr = 1;
        tick();
        #1;
        chk("idle_bus_after_reset", BusMuxOut, 32'h0);
        chk("mar_after_reset", MAR, 32'h0);
        chk("ir_after_reset", IR_q, 32'h0);

        // Reset clears populated registers
        ld_r(5, 32'h1234);
        rd("r5_loaded", 5, 32'h1234);
        InPort = 32'h77; InPortout = 1; PCin = 1; tick();
        Mdatain = 32'hAB; Read = 1; MDRin = 1; tick();
        InPort = 32'h5; InPortout = 1; Zin = 1; tick();
        InPort = 32'hCAFE; InPortout = 1; MARin = 1; tick();
        rd("z_lo_passthru", 19, 32'h5);
        chk("mar_load", MAR, 32'hCAFE);
        clr = 1; Rin[5] = 1; InPort = 32'h9; InPortout = 1; tick();
        rd("r5_cleared", 5, 32'h0);
        rd("pc_cleared", 20, 32'h0);
        rd("mdr_cleared", 21, 32'h0);
        rd("zlo_cleared", 19, 32'h0);
        chk("mar_cleared", MAR, 32'h0);
        #1;
        chk("idle_bus", BusMuxOut, 32'h0);

        // MDR from memory, then from bus
        Mdatain = 32'h22; Read = 1; MDRin = 1; tick();
        MDRout = 1; Rin[2] = 1; tick();
        rd("r2_from_mdr", 2, 32'h22);
        InPort = 32'h55; InPortout = 1; Read = 0; MDRin = 1; Mdatain = 32'hDEAD; tick();
        rd("mdr_from_bus", 21, 32'h55);

        // AND / OR with Y = R2
        ld_r(3, 32'h24);
        Rout[2] = 1; Yin = 1; tick();
        Rout[3] = 1; AND = 1; Zin = 1; tick();
        rd("and_zlo", 19, 32'h20);
        rd("and_zhi", 18, 32'h0);
        Rout[3] = 1; OR = 1; Zin = 1; tick();
        rd("or_zlo", 19, 32'h26);

        // NEG / NOT and op priority
        ld_r(3, 32'h1);
        Rout[3] = 1; NEG = 1; Zin = 1; tick();
        rd("neg_zlo", 19, 32'hFFFFFFFF);
        rd("neg_zhi", 18, 32'hFFFFFFFF);
        Rout[3] = 1; NOT = 1; Zin = 1; tick();
        rd("not_zlo", 19, 32'hFFFFFFFE);
        Rout[3] = 1; AND = 1; NOT = 1; NEG = 1; Zin = 1; tick();
        rd("and_over_not", 19, 32'h0);
        rd("and_over_not_zhi", 18, 32'h0);
        Rout[3] = 1; OR = 1; NEG = 1; Zin = 1; tick();
        rd("or_over_neg", 19, 32'h23);

        // Z_LO -> Y hop, then Y | 0 reproduces it
        Zlowout = 1; Yin = 1; tick();
        InPort = 32'h0; InPortout = 1; OR = 1; Zin = 1; tick();
        rd("z_to_y_hop", 19, 32'h23);

        // Encoder priority
        ld_r(1, 32'h11);
        ld_r(4, 32'h44);
        Rout[1] = 1; Rout[4] = 1;
        #1;
        chk("prio_r1_over_r4", BusMuxOut, 32'h11);
`ifdef BUS_CONFLICT_CHECK_EN
        chk("conflict_set", {31'd0, bus_conflict}, 32'h1);
        Rout[1] = 0;
        #1;
        chk("conflict_clear", {31'd0, bus_conflict}, 32'h0);
`endif
        idle();
        InPort = 32'hA; InPortout = 1; HIin = 1; tick();
        InPort = 32'hB; InPortout = 1; LOin = 1; tick();
        HIout = 1; LOout = 1;
        #1;
        chk("prio_hi_over_lo", BusMuxOut, 32'hA);
        idle();
        rd("lo_read", 17, 32'hB);
        Rout[15] = 1; HIout = 1; Cout = 1;
        #1;
        chk("prio_r15_over_hi", BusMuxOut, 32'h0);
        idle();

        // Sign-extended IR field
        InPort = 32'h00040000; InPortout = 1; IRin = 1; tick();
        chk("ir_q_load", IR_q, 32'h00040000);
        rd("cout_sext_neg", 23, 32'hFFFC0000);
        InPort = 32'hFFF12345; InPortout = 1; IRin = 1; tick();
        rd("cout_sext_pos", 23, 32'h00012345);

        // PC increment priority and wrap
        InPort = 32'h10; InPortout = 1; PCin = 1; tick();
        rd("pc_load", 20, 32'h10);
        InPort = 32'h99; InPortout = 1; PCin = 1; IncPC = 1; tick();
        rd("pc_inc_over_load", 20, 32'h11);
        InPort = 32'h99; InPortout = 1; PCin = 1; tick();
        rd("pc_load_alone", 20, 32'h99);
        InPort = 32'hFFFFFFFF; InPortout = 1; PCin = 1; tick();
        IncPC = 1; tick();
        rd("pc_wrap", 20, 32'h0);

        // Self-load captures the pre-edge bus value
        ld_r(6, 32'h7);
        Rout[6] = 1; Rin[6] = 1; Rin[7] = 1; tick();
        rd("r7_copy", 7, 32'h7);
        rd("r6_hold", 6, 32'h7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
